// File: rtl/t5_wbarb.sv
// Data-first arbiter merging the core's instruction and data ports onto one memory bus; grant one cycle after stb, ack passes through combinationally.
// A master waits on its ack, with no other backpressure; a dropped stb aborts the cycle; a watchdog forces an ack with zero data after TOUT cycles.
module t5_wbarb #(
  parameter int DMAX = 4,
  parameter int TOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [29:0] iwb_adr,
  input  logic        iwb_stb,
  input  logic        iwb_wre,
  input  logic [3:0]  iwb_sel,
  output logic [31:0] iwb_dat,
  output logic        iwb_ack,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_dto,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_wre,
  input  logic        dwb_stb,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  output logic [29:0] mwb_adr,
  output logic [31:0] mwb_dto,
  output logic [3:0]  mwb_sel,
  output logic        mwb_wre,
  output logic        mwb_stb,
  input  logic [31:0] mwb_dti,
  input  logic        mwb_ack,
  output logic        mwb_bto
);

  typedef enum logic [1:0] {IDLE, GNTI, GNTD} state_t;

  localparam logic [3:0]  DMAX_C  = 4'(DMAX);
  localparam logic [15:0] TOUT_M1 = 16'(TOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  dcnt, dcnt_nxt;
  logic [15:0] wdog, wdog_nxt;
  logic        bto_nxt;
  logic        gnt_stb;
  logic        done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      dcnt    <= 4'd0;
      wdog    <= 16'd0;
      mwb_bto <= 1'b0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      wdog    <= wdog_nxt;
      mwb_bto <= bto_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    wdog_nxt  = 16'd0;
    bto_nxt   = mwb_bto;
    gnt_stb   = 1'b0;
    done      = 1'b0;
    mwb_adr   = 30'd0;
    mwb_dto   = 32'd0;
    mwb_sel   = 4'd0;
    mwb_wre   = 1'b0;
    mwb_stb   = 1'b0;
    iwb_ack   = 1'b0;
    dwb_ack   = 1'b0;
    iwb_dat   = mwb_dti;
    dwb_dti   = mwb_dti;

    case (state)
      GNTI: begin
        mwb_adr = iwb_adr;
        mwb_sel = iwb_sel;
        mwb_wre = iwb_wre;
        gnt_stb = iwb_stb;
      end
      GNTD: begin
        mwb_adr = dwb_adr;
        mwb_sel = dwb_sel;
        mwb_wre = dwb_wre;
        mwb_dto = dwb_dto;
        gnt_stb = dwb_stb;
      end
      default: begin
        // Data wins unless instruction fetch has waited out DMAX data grants.
        if (dwb_stb && (!iwb_stb || dcnt < DMAX_C))
          state_nxt = GNTD;
        else if (iwb_stb)
          state_nxt = GNTI;
      end
    endcase

    if (state != IDLE) begin
      mwb_stb = gnt_stb;
      if (mwb_ack) begin
        done = 1'b1;
      end else if (!gnt_stb) begin
        state_nxt = IDLE;
      end else if (wdog == TOUT_M1) begin
        // Forced termination: the master sees an ack carrying zero data.
        done    = 1'b1;
        iwb_dat = 32'd0;
        dwb_dti = 32'd0;
        bto_nxt = 1'b1;
      end else begin
        wdog_nxt = wdog + 16'd1;
      end
    end

    if (done) begin
      state_nxt = IDLE;
      if (state == GNTI) begin
        iwb_ack  = 1'b1;
        dcnt_nxt = 4'd0;
      end else begin
        dwb_ack  = 1'b1;
        if (!iwb_stb)
          dcnt_nxt = 4'd0;
        else if (dcnt < DMAX_C)
          dcnt_nxt = dcnt + 4'd1;
        else
          dcnt_nxt = DMAX_C;
      end
    end
  end

endmodule

// File: tb/tb_t5_wbarb.sv
// Scoreboarded bench for t5_wbarb: stimulus queues expected acks, a negedge monitor checks them.
module tb_t5_wbarb;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [29:0] iwb_adr;
  logic        iwb_stb;
  logic        iwb_wre;
  logic [3:0]  iwb_sel;
  logic [31:0] iwb_dat;
  logic        iwb_ack;
  logic [29:0] dwb_adr;
  logic [31:0] dwb_dto;
  logic [3:0]  dwb_sel;
  logic        dwb_wre;
  logic        dwb_stb;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic [29:0] mwb_adr;
  logic [31:0] mwb_dto;
  logic [3:0]  mwb_sel;
  logic        mwb_wre;
  logic        mwb_stb;
  logic [31:0] mwb_dti;
  logic        mwb_ack;
  logic        mwb_bto;

  logic        auto_en;
  logic        man_ack;
  logic [31:0] man_dti;

  typedef struct {
    logic        is_d;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   acks_seen = 0;

  always #5 sys_clk = ~sys_clk;

  // Slave model: either scripted per cycle, or an immediate responder returning {adr,2'b11}.
  assign mwb_ack = auto_en ? mwb_stb : man_ack;
  assign mwb_dti = auto_en ? {mwb_adr, 2'b11} : man_dti;

  t5_wbarb #(.DMAX(4), .TOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
    .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_wre(dwb_wre),
    .dwb_stb(dwb_stb), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mwb_adr(mwb_adr), .mwb_dto(mwb_dto), .mwb_sel(mwb_sel), .mwb_wre(mwb_wre),
    .mwb_stb(mwb_stb), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack), .mwb_bto(mwb_bto)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic samp;
    @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (iwb_ack || dwb_ack) begin
      acks_seen++;
      chk("ack_exclusive", 32'(iwb_ack & dwb_ack), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=i%0d/d%0d required=none", iwb_ack, dwb_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_master", 32'(dwb_ack), 32'(e.is_d));
        chk("ack_data", dwb_ack ? dwb_dti : iwb_dat, e.dat);
      end
    end
  end

  initial begin
    int base;
    int early;
    sys_rst = 1'b1;
    iwb_adr = '0; iwb_stb = 1'b0; iwb_wre = 1'b0; iwb_sel = '0;
    dwb_adr = '0; dwb_dto = '0; dwb_sel = '0; dwb_wre = 1'b0; dwb_stb = 1'b0;
    auto_en = 1'b0; man_ack = 1'b0; man_dti = '0;

    repeat (3) @(posedge sys_clk);
    #1;
    samp;
    chk("rst_mwb_stb", 32'(mwb_stb), 32'd0);
    chk("rst_mwb_adr", 32'(mwb_adr), 32'd0);
    chk("rst_mwb_sel_wre", {27'd0, mwb_sel, mwb_wre}, 32'd0);
    chk("rst_mwb_dto", mwb_dto, 32'd0);
    chk("rst_acks", {30'd0, iwb_ack, dwb_ack}, 32'd0);
    chk("rst_bto", 32'(mwb_bto), 32'd0);
    tick;
    sys_rst = 1'b0;

    // Single fetch
    tick;
    iwb_stb = 1'b1; iwb_adr = 30'h0000100; iwb_sel = 4'hF;
    samp;
    chk("fetch_c0_stb", 32'(mwb_stb), 32'd0);
    tick; samp;
    chk("fetch_c1_stb", 32'(mwb_stb), 32'd1);
    chk("fetch_c1_adr", 32'(mwb_adr), 32'h100);
    chk("fetch_c1_iack", 32'(iwb_ack), 32'd0);
    tick;
    man_ack = 1'b1; man_dti = 32'h00000013;
    exp_q.push_back('{1'b0, 32'h00000013});
    samp;
    chk("fetch_c2_dack", 32'(dwb_ack), 32'd0);
    tick;
    man_ack = 1'b0;
    samp;
    chk("fetch_c3_idle", 32'(mwb_stb), 32'd0);
    iwb_stb = 1'b0;

    // Stray ack in IDLE
    tick;
    man_ack = 1'b1; man_dti = 32'h0000FFFF;
    samp;
    chk("stray_acks", {30'd0, iwb_ack, dwb_ack}, 32'd0);
    tick;
    man_ack = 1'b0;
    samp;
    chk("stray_stb", 32'(mwb_stb), 32'd0);

    // Contention: data first, instruction after turnaround
    tick;
    iwb_stb = 1'b1; iwb_adr = 30'h0000040;
    dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_dto = 32'hDEADBEEF; dwb_sel = 4'hF; dwb_adr = 30'h0000080;
    tick; samp;
    chk("cont_d_wre", 32'(mwb_wre), 32'd1);
    chk("cont_d_dto", mwb_dto, 32'hDEADBEEF);
    chk("cont_d_adr", 32'(mwb_adr), 32'h80);
    chk("cont_d_sel", 32'(mwb_sel), 32'hF);
    tick;
    man_ack = 1'b1; man_dti = 32'h0;
    exp_q.push_back('{1'b1, 32'h0});
    samp;
    tick;
    man_ack = 1'b0; dwb_stb = 1'b0; dwb_wre = 1'b0;
    samp;
    chk("cont_turn_stb", 32'(mwb_stb), 32'd0);
    tick; samp;
    chk("cont_i_stb", 32'(mwb_stb), 32'd1);
    chk("cont_i_adr", 32'(mwb_adr), 32'h40);
    chk("cont_i_wre", 32'(mwb_wre), 32'd0);
    chk("cont_i_dto", mwb_dto, 32'd0);
    tick;
    man_ack = 1'b1; man_dti = 32'h00000055;
    exp_q.push_back('{1'b0, 32'h00000055});
    samp;
    tick;
    man_ack = 1'b0;
    samp;
    iwb_stb = 1'b0;

    // Starvation guard: D,D,D,D,I repeating
    tick;
    auto_en = 1'b1; iwb_stb = 1'b1; dwb_stb = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back('{1'b1, 32'h00000203});
      exp_q.push_back('{1'b0, 32'h00000103});
    end
    base = acks_seen;
    for (int n = 0; n < 100 && acks_seen < base + 10; n++) tick;
    iwb_stb = 1'b0; dwb_stb = 1'b0; auto_en = 1'b0;
    chk("starve_ack_count", 32'(acks_seen - base), 32'd10);
    chk("starve_q_empty", 32'(exp_q.size()), 32'd0);

    // Watchdog on a stuck data read
    tick;
    dwb_stb = 1'b1; dwb_adr = 30'h0000080; man_dti = 32'hFFFFFFFF;
    exp_q.push_back('{1'b1, 32'h0});
    early = 0;
    for (int c = 1; c <= 7; c++) begin
      tick; samp;
      if (dwb_ack || iwb_ack) early++;
    end
    chk("wd_no_early_ack", 32'(early), 32'd0);
    chk("wd_bto_before", 32'(mwb_bto), 32'd0);
    tick; samp;
    chk("wd_dack", 32'(dwb_ack), 32'd1);
    chk("wd_iwb_dat_zero", iwb_dat, 32'd0);
    tick; samp;
    chk("wd_bto_set", 32'(mwb_bto), 32'd1);
    chk("wd_idle_stb", 32'(mwb_stb), 32'd0);
    dwb_stb = 1'b0;

    // Abort in second GNTD cycle, then fetch proves IDLE was reached
    tick;
    dwb_stb = 1'b1;
    tick; samp;
    chk("ab_c1_stb", 32'(mwb_stb), 32'd1);
    tick;
    dwb_stb = 1'b0;
    samp;
    chk("ab_c2_stb", 32'(mwb_stb), 32'd0);
    tick;
    iwb_stb = 1'b1; iwb_adr = 30'h0000040;
    samp;
    chk("ab_idle_stb", 32'(mwb_stb), 32'd0);
    tick; samp;
    chk("ab_then_fetch_adr", 32'(mwb_adr), 32'h40);
    chk("ab_bto_sticky", 32'(mwb_bto), 32'd1);

    // Reset in the middle of GNTI
    #2;
    sys_rst = 1'b1;
    man_ack = 1'b1;
    #1;
    chk("rst_mid_stb", 32'(mwb_stb), 32'd0);
    chk("rst_mid_iack", 32'(iwb_ack), 32'd0);
    chk("rst_mid_adr", 32'(mwb_adr), 32'd0);
    chk("rst_mid_bto", 32'(mwb_bto), 32'd0);
    tick;
    iwb_stb = 1'b0; man_ack = 1'b0;
    sys_rst = 1'b0;
    tick; samp;
    chk("post_rst_stb", 32'(mwb_stb), 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
